// File: rtl/lut_pipe_if.sv
// Valid/ready activation-vector channel between PolyLUT-Add layers.
// The master drives data/valid and the slave drives ready.
interface lut_pipe_if #(
  parameter int DataWidth = 200
) ();
  logic [DataWidth-1:0] data;
  logic                 valid;
  logic                 ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/lut_layer_elastic_pipe.sv
// Elastic multi-stage pipeline register (main + skid per stage) with flush and occupancy.
// Optional macro LUTPIPE_STALL_CNT_EN adds the stall_cnt output port.
//
// state | meaning
// EMPTY | main and skid both empty
// ONE   | main holds a vector, skid empty
// TWO   | main and skid both hold a vector; upstream ready is low
module lut_layer_elastic_pipe #(
  parameter int DataWidth = 200,
  parameter int STAGES    = 1,
  parameter int OCC_W     = $clog2(2*STAGES+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  lut_pipe_if.slave        in_bus,
  lut_pipe_if.master       out_bus,
  output logic [OCC_W-1:0] occupancy
`ifdef LUTPIPE_STALL_CNT_EN
  ,
  output logic [31:0]      stall_cnt
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } stage_state_t;

  stage_state_t         state_q [STAGES];
  stage_state_t         state_d [STAGES];
  logic [DataWidth-1:0] main_q  [STAGES];
  logic [DataWidth-1:0] skid_q  [STAGES];

  // Link k is the input side of stage k; link STAGES is the block output.
  logic [DataWidth-1:0] link_data [STAGES+1];
  logic [STAGES:0]      link_valid;
  logic [STAGES:0]      link_ready;
  logic [STAGES:0]      link_fire;

  logic [STAGES-1:0]    ld_main_in;
  logic [STAGES-1:0]    ld_main_skid;
  logic [STAGES-1:0]    ld_skid;
  logic                 live;
  logic [OCC_W-1:0]     occ_q;

  assign live = rst & ~flush;

  // Ready depends only on registered skid state, so out_ready never reaches in_ready.
  always_comb begin
    link_data[0]       = in_bus.data;
    link_valid[0]      = in_bus.valid;
    link_ready[STAGES] = out_bus.ready;
    for (int k = 0; k < STAGES; k++) begin
      link_data[k+1]  = main_q[k];
      link_valid[k+1] = (state_q[k] != EMPTY);
      link_ready[k]   = live & (state_q[k] != TWO);
    end
  end

  assign link_fire = link_valid & link_ready;

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      state_d[k]      = state_q[k];
      ld_main_in[k]   = 1'b0;
      ld_main_skid[k] = 1'b0;
      ld_skid[k]      = 1'b0;
      case (state_q[k])
        EMPTY: begin
          if (link_fire[k]) begin
            state_d[k]    = ONE;
            ld_main_in[k] = 1'b1;
          end
        end
        ONE: begin
          case ({link_fire[k], link_fire[k+1]})
            2'b11: ld_main_in[k] = 1'b1;
            2'b10: begin
              state_d[k] = TWO;
              ld_skid[k] = 1'b1;
            end
            2'b01: state_d[k] = EMPTY;
            default: ;
          endcase
        end
        TWO: begin
          if (link_fire[k+1]) begin
            state_d[k]      = ONE;
            ld_main_skid[k] = 1'b1;
          end
        end
        default: state_d[k] = EMPTY;
      endcase
      if (!live) state_d[k] = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < STAGES; k++) begin
      if (!rst) begin
        state_q[k] <= EMPTY;
        main_q[k]  <= '0;
        skid_q[k]  <= '0;
      end else begin
        state_q[k] <= state_d[k];
        if (ld_main_in[k])        main_q[k] <= link_data[k];
        else if (ld_main_skid[k]) main_q[k] <= skid_q[k];
        if (ld_skid[k])           skid_q[k] <= link_data[k];
      end
    end
  end

  // Internal stage-to-stage moves never change the total held count.
  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      occ_q <= '0;
    end else begin
      case ({link_fire[0], link_fire[STAGES]})
        2'b10:   occ_q <= occ_q + OCC_W'(1);
        2'b01:   occ_q <= occ_q - OCC_W'(1);
        default: ;
      endcase
    end
  end

  assign in_bus.ready  = link_ready[0];
  assign out_bus.valid = link_valid[STAGES];
  assign out_bus.data  = link_data[STAGES];
  assign occupancy     = occ_q;

`ifdef LUTPIPE_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst)                                 stall_cnt <= '0;
    else if (out_bus.valid && !out_bus.ready) stall_cnt <= stall_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_lut_layer_elastic_pipe.sv
// Directed bench for lut_layer_elastic_pipe with STAGES=1, 2 and 3 instances.
// Stall counter checks compile in only when LUTPIPE_STALL_CNT_EN is defined.
module tb_lut_layer_elastic_pipe;
  localparam int DW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst1, rst2, rst3, fl1, fl2, fl3;
  logic [1:0] occ1;
  logic [2:0] occ2, occ3;
`ifdef LUTPIPE_STALL_CNT_EN
  logic [31:0] sc1, sc2, sc3;
`endif

  lut_pipe_if #(.DataWidth(DW)) p1_in ();
  lut_pipe_if #(.DataWidth(DW)) p1_out ();
  lut_pipe_if #(.DataWidth(DW)) p2_in ();
  lut_pipe_if #(.DataWidth(DW)) p2_out ();
  lut_pipe_if #(.DataWidth(DW)) p3_in ();
  lut_pipe_if #(.DataWidth(DW)) p3_out ();

  lut_layer_elastic_pipe #(.DataWidth(DW), .STAGES(1)) dut1 (
    .clk(clk), .rst(rst1), .flush(fl1), .in_bus(p1_in), .out_bus(p1_out), .occupancy(occ1)
`ifdef LUTPIPE_STALL_CNT_EN
    , .stall_cnt(sc1)
`endif
  );
  lut_layer_elastic_pipe #(.DataWidth(DW), .STAGES(2)) dut2 (
    .clk(clk), .rst(rst2), .flush(fl2), .in_bus(p2_in), .out_bus(p2_out), .occupancy(occ2)
`ifdef LUTPIPE_STALL_CNT_EN
    , .stall_cnt(sc2)
`endif
  );
  lut_layer_elastic_pipe #(.DataWidth(DW), .STAGES(3)) dut3 (
    .clk(clk), .rst(rst3), .flush(fl3), .in_bus(p3_in), .out_bus(p3_out), .occupancy(occ3)
`ifdef LUTPIPE_STALL_CNT_EN
    , .stall_cnt(sc3)
`endif
  );

  typedef struct packed {
    logic          fl;
    logic          iv;
    logic [DW-1:0] id;
    logic          ordy;
    logic          ov;
    logic [DW-1:0] od;
    logic          ir;
    logic [1:0]    occ;
  } vec_t;

  vec_t tbl [0:10];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  initial begin
    // fl, iv, id, ordy | ov, od, ir, occ   (STAGES=1)
    tbl[0]  = '{1'b0, 1'b1, 8'h11, 1'b0, 1'b0, 8'h00, 1'b1, 2'd0};
    tbl[1]  = '{1'b0, 1'b1, 8'h22, 1'b0, 1'b1, 8'h11, 1'b1, 2'd1};
    tbl[2]  = '{1'b0, 1'b1, 8'h33, 1'b0, 1'b1, 8'h11, 1'b0, 2'd2};
    tbl[3]  = '{1'b0, 1'b1, 8'h33, 1'b1, 1'b1, 8'h11, 1'b0, 2'd2};
    tbl[4]  = '{1'b0, 1'b1, 8'h33, 1'b1, 1'b1, 8'h22, 1'b1, 2'd1};
    tbl[5]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h33, 1'b1, 2'd1};
    tbl[6]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h33, 1'b1, 2'd0};
    tbl[7]  = '{1'b1, 1'b1, 8'h44, 1'b0, 1'b0, 8'h33, 1'b0, 2'd0};
    tbl[8]  = '{1'b0, 1'b1, 8'h55, 1'b0, 1'b0, 8'h33, 1'b1, 2'd0};
    tbl[9]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h55, 1'b0, 2'd1};
    tbl[10] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h55, 1'b1, 2'd0};

    rst1 = 1'b0; rst2 = 1'b0; rst3 = 1'b0;
    fl1  = 1'b0; fl2  = 1'b0; fl3  = 1'b0;
    p1_in.valid = 1'b1; p2_in.valid = 1'b1; p3_in.valid = 1'b1;
    p1_in.data  = 8'h5A; p2_in.data = 8'h5A; p3_in.data = 8'h5A;
    p1_out.ready = 1'b1; p2_out.ready = 1'b1; p3_out.ready = 1'b1;

    // Reset held for three edges with traffic offered on both sides.
    for (int r = 0; r < 3; r++) begin
      @(negedge clk); #1;
      chk("rst_ov",  32'(p3_out.valid), 32'd0);
      chk("rst_od",  32'(p3_out.data),  32'd0);
      chk("rst_occ", 32'(occ3),         32'd0);
      chk("rst_ir",  32'(p3_in.ready),  32'd0);
    end
    rst1 = 1'b1; rst2 = 1'b1; rst3 = 1'b1;
    p1_in.valid = 1'b0; p2_in.valid = 1'b0; p3_in.valid = 1'b0;
    #1;
    chk("rel_ir3", 32'(p3_in.ready), 32'd1);
    chk("rel_ir2", 32'(p2_in.ready), 32'd1);

    // Streaming, STAGES=3: 1..10 in, out 3 cycles later.
    for (int i = 0; i < 15; i++) begin
      int acc, emt;
      @(negedge clk);
      p3_in.valid  = (i < 10);
      p3_in.data   = 8'(i + 1);
      p3_out.ready = 1'b1;
      #1;
      acc = (i < 10) ? i : 10;
      emt = (i < 3) ? 0 : ((i - 3 < 10) ? i - 3 : 10);
      chk("str_occ", 32'(occ3), 32'(acc - emt));
      chk("str_ov", 32'(p3_out.valid), 32'((i >= 3) && (i < 13)));
      if (i >= 3 && i < 13) chk("str_od", 32'(p3_out.data), 32'(i - 2));
      if (i < 10) chk("str_ir", 32'(p3_in.ready), 32'd1);
    end

    // Backpressure, STAGES=3: capacity 6, head held stable.
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      p3_in.valid  = (i < 8);
      p3_in.data   = 8'(i + 1);
      p3_out.ready = 1'b0;
      #1;
      chk("bp_occ", 32'(occ3), 32'((i < 6) ? i : 6));
      if (i < 8) chk("bp_ir", 32'(p3_in.ready), 32'(i < 6));
      if (i >= 3) begin
        chk("bp_ov", 32'(p3_out.valid), 32'd1);
        chk("bp_od", 32'(p3_out.data),  32'd1);
      end
    end
    for (int j = 0; j < 7; j++) begin
      @(negedge clk);
      p3_in.valid  = 1'b0;
      p3_out.ready = 1'b1;
      #1;
      chk("drn_ov",  32'(p3_out.valid), 32'(j < 6));
      chk("drn_occ", 32'(occ3),         32'(6 - j));
      if (j < 6) chk("drn_od", 32'(p3_out.data), 32'(j + 1));
    end

    // Table-driven sequence on the single-stage instance.
    for (int i = 0; i <= 10; i++) begin
      @(negedge clk);
      fl1          = tbl[i].fl;
      p1_in.valid  = tbl[i].iv;
      p1_in.data   = tbl[i].id;
      p1_out.ready = tbl[i].ordy;
      #1;
      chk($sformatf("tbl%0d_ov", i),  32'(p1_out.valid), 32'(tbl[i].ov));
      chk($sformatf("tbl%0d_od", i),  32'(p1_out.data),  32'(tbl[i].od));
      chk($sformatf("tbl%0d_ir", i),  32'(p1_in.ready),  32'(tbl[i].ir));
      chk($sformatf("tbl%0d_occ", i), 32'(occ1),         32'(tbl[i].occ));
    end

`ifdef LUTPIPE_STALL_CNT_EN
    @(negedge clk);
    rst1 = 1'b0; fl1 = 1'b0; p1_in.valid = 1'b0; p1_out.ready = 1'b0;
    @(negedge clk);
    rst1 = 1'b1; p1_in.valid = 1'b1; p1_in.data = 8'h66;
    #1;
    chk("sc_rst", sc1, 32'd0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      p1_in.valid = 1'b0;
      #1;
      chk("sc_cnt", sc1, 32'(k));
    end
    @(negedge clk);
    p1_out.ready = 1'b1;
    #1;
    chk("sc_od", 32'(p1_out.data), 32'h66);
    chk("sc_five", sc1, 32'd5);
    @(negedge clk);
    fl1 = 1'b1;
    #1;
    chk("sc_fl", sc1, 32'd5);
    @(negedge clk);
    fl1 = 1'b0;
    #1;
    chk("sc_after_fl", sc1, 32'd5);
    @(negedge clk);
    rst1 = 1'b0;
    @(negedge clk);
    rst1 = 1'b1;
    #1;
    chk("sc_cleared", sc1, 32'd0);
`endif

    // Flush, STAGES=2: fill 4, flush with in_valid high, then push 0xA5.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      p2_in.valid  = 1'b1;
      p2_in.data   = 8'(i + 1);
      p2_out.ready = 1'b0;
      #1;
      chk("fl_fill_ir",  32'(p2_in.ready), 32'd1);
      chk("fl_fill_occ", 32'(occ2),        32'(i));
    end
    @(negedge clk);
    fl2 = 1'b1; p2_in.valid = 1'b1; p2_in.data = 8'h77;
    #1;
    chk("fl_occ4", 32'(occ2),         32'd4);
    chk("fl_ir0",  32'(p2_in.ready),  32'd0);
    chk("fl_od1",  32'(p2_out.data),  32'd1);
    @(negedge clk);
    fl2 = 1'b0; p2_in.data = 8'hA5;
    #1;
    chk("fl_occ0", 32'(occ2),         32'd0);
    chk("fl_ov0",  32'(p2_out.valid), 32'd0);
    chk("fl_ir1",  32'(p2_in.ready),  32'd1);
    @(negedge clk);
    p2_in.valid = 1'b0; p2_out.ready = 1'b1;
    #1;
    chk("a5_t1_ov",  32'(p2_out.valid), 32'd0);
    chk("a5_t1_occ", 32'(occ2),         32'd1);
    @(negedge clk); #1;
    chk("a5_t2_ov", 32'(p2_out.valid), 32'd1);
    chk("a5_t2_od", 32'(p2_out.data),  32'hA5);
    @(negedge clk); #1;
    chk("a5_done_ov",  32'(p2_out.valid), 32'd0);
    chk("a5_done_occ", 32'(occ2),         32'd0);

    // Reset mid-stream, STAGES=2, with an out_ready pulse during reset.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      p2_in.valid = 1'b1; p2_in.data = 8'(8'h31 + i); p2_out.ready = 1'b0;
    end
    @(negedge clk);
    p2_in.valid = 1'b0;
    #1;
    chk("mr_occ3", 32'(occ2),         32'd3);
    chk("mr_ov1",  32'(p2_out.valid), 32'd1);
    @(negedge clk);
    rst2 = 1'b0; p2_out.ready = 1'b1;
    #1;
    chk("mr_ir0", 32'(p2_in.ready), 32'd0);
    @(negedge clk);
    rst2 = 1'b1;
    #1;
    chk("mr_occ0", 32'(occ2),         32'd0);
    chk("mr_ov0",  32'(p2_out.valid), 32'd0);
    chk("mr_od0",  32'(p2_out.data),  32'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); #1;
      chk("mr_stale", 32'(p2_out.valid), 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/lut_layer_elastic_pipe.md
Name: lut_layer_elastic_pipe

Overview:
- Parametrised elastic pipeline register placed between PolyLUT-Add layer/adder pairs.
- Supersedes the fixed single-stage, always-enabled layer register.
- Adds a configurable stage count, a valid/ready handshake with full-throughput skid buffering, a synchronous flush and an occupancy count.
- Lets a downstream consumer stall the layer chain without losing or duplicating activations.

Parameters:
- DataWidth, 200, bit width of one activation vector (e.g. 1568 for the input layer, 20 for the output).
- STAGES, 1, number of chained elastic stages; must be at least 1.
- OCC_W, $clog2(2*STAGES+1), width of the occupancy output (derived; do not override).

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  synchronous reset, active-low; sampled on rising clk.
- flush  in  1  synchronous discard of all held vectors.
- in_data  in  DataWidth  upstream activation vector.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block accepts in_data this cycle.
- out_data  out  DataWidth  activation vector to the next layer.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts out_data this cycle.
- occupancy  out  OCC_W  number of vectors currently held, 0..2*STAGES.

Behaviour:
- Transfer definitions:
  - in fire = in_valid & in_ready.
  - out fire = out_valid & out_ready.
- Each stage holds a main register and a skid register, each with its own valid bit.
  - Stage output valid = main valid; stage output data = main data.
  - Stage upstream ready = !skid valid (registered; no combinational path from out_ready to in_ready).
- Per-stage state machine (EMPTY / ONE / TWO):
  - EMPTY + in fire -> main<=in, ONE.
  - ONE + in fire + out fire -> main<=in, ONE.
  - ONE + in fire, no out fire -> skid<=in, TWO.
  - ONE + out fire, no in fire -> EMPTY.
  - TWO + out fire -> main<=skid, ONE. In fire cannot occur in TWO.
- Stage k output feeds stage k+1 input. out_* come from the last stage; in_ready comes from stage 0.
- in_ready = rst & !flush & !skid_valid[0]: forced 0 while reset or flush is asserted.
- Latency:
  - A vector accepted at cycle t is first presented on out_data at cycle t+STAGES, with no stalls in between.
  - Throughput is 1 vector/cycle in steady state.
  - Capacity is 2*STAGES vectors.
- Ordering is strictly FIFO. Data is never dropped or duplicated except by flush.
- occupancy: registered count of set valid bits across all stages.
  - Updates +1 on in fire only, -1 on out fire only, unchanged on both or neither.
  - Saturation is impossible by construction.
- Reset (rst=0 at a clk edge):
  - All valid bits 0 and all data registers 0, so out_data=0, out_valid=0, occupancy=0.
  - in_ready=0 while rst=0 and 1 in the first cycle after release.
  - Reset mid-stream discards everything; an out_ready pulse during reset has no effect.
- Flush (flush=1 at a clk edge):
  - All valid bits clear and occupancy goes to 0 next cycle. Data registers keep their values (don't-care).
  - Flush has priority over simultaneous in_valid: no in fire during flush.
  - An out fire in the flush cycle is still counted as delivered.
- Data registers load only on a fire. Out_data is stable while out_valid=1 and out_ready=0.
- out_valid, once high, stays high until out fire, flush or reset.

Optional Feature:
- Macro LUTPIPE_STALL_CNT_EN.
- When defined, adds output port stall_cnt [31:0]: counts cycles where out_valid=1 & out_ready=0.
  - Wraps at 2^32.
  - Cleared by reset; not cleared by flush.
- When undefined, the port and its counter are absent; all other behaviour is identical.

Test Plan:
- Reset: rst=0 for 3 cycles with in_valid=1, out_ready=1 -> out_valid=0, out_data=0, occupancy=0, in_ready=0; first cycle after release in_ready=1.
- Streaming, STAGES=3, out_ready=1, in_valid=1, in_data=1..10 on consecutive cycles -> out_data 1..10 on consecutive cycles starting 3 cycles after first accept; occupancy steady at 3.
- Backpressure, STAGES=3, out_ready=0, push 8 vectors -> accepts exactly 6, in_ready=0 after 6th, occupancy=6, out_data=1 held stable; then out_ready=1 -> emits 1..6 in order, one per cycle, occupancy back to 0.
- Flush: STAGES=2, hold 4 vectors, assert flush with in_valid=1 -> next cycle occupancy=0, out_valid=0, in_ready=0 during flush, no vector accepted; subsequent push of 0xA5 emerges after 2 cycles.
- Reset mid-operation: STAGES=2, occupancy=3, rst=0 for 1 cycle -> occupancy=0, out_valid=0, out_data=0; no stale vector ever reappears.
- Stall counter (LUTPIPE_STALL_CNT_EN): STAGES=1, one vector held with out_ready=0 for 5 cycles then accepted -> stall_cnt=5; flush leaves it 5; reset returns it to 0.
